// File: rtl/ret_marker_nop_injector.sv
// Return-marker producer: passes fetched instructions to the decoder through one
// registered slot and follows every accepted RET with the marker NOP.
module ret_marker_nop_injector #(
    parameter logic [31:0] NOP_INSTR = 32'h00100013,
    parameter int          PC_WIDTH  = 64,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 en_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [31:0]          instr_i,
    input  logic [PC_WIDTH-1:0]  pc_i,
    input  logic                 fetch_ex_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [31:0]          instr_o,
    output logic [PC_WIDTH-1:0]  pc_o,
    output logic                 fetch_ex_o,
    output logic                 injected_o,
    output logic [CNT_WIDTH-1:0] inject_cnt_o
);

    typedef enum logic {
        IDLE,
        INJECT
    } state_t;

    state_t              state;
    logic [PC_WIDTH-1:0] marker_pc;
    logic                slot_free;
    logic                in_compressed;
    logic                in_is_ret;
    logic                accept;

    // A word flagged with a fetch exception never counts as a return.
    assign in_compressed = (instr_i[1:0] != 2'b11);
    assign in_is_ret     = !fetch_ex_i &&
                           ((instr_i == 32'h00008067) ||
                            (in_compressed && (instr_i[15:0] == 16'h8082)));

    assign slot_free = !valid_o || ready_i;
    assign ready_o   = !flush_i && (state == IDLE) && slot_free;
    assign accept    = valid_i && ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            valid_o      <= 1'b0;
            instr_o      <= '0;
            pc_o         <= '0;
            fetch_ex_o   <= 1'b0;
            injected_o   <= 1'b0;
            inject_cnt_o <= '0;
            marker_pc    <= '0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
            state   <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        valid_o    <= 1'b1;
                        instr_o    <= instr_i;
                        pc_o       <= pc_i;
                        fetch_ex_o <= fetch_ex_i;
                        injected_o <= 1'b0;
                        // The marker takes the address of the word after the RET.
                        if (in_is_ret && en_i) begin
                            state     <= INJECT;
                            marker_pc <= pc_i + (in_compressed ? PC_WIDTH'(2) : PC_WIDTH'(4));
                        end
                    end else if (slot_free) begin
                        valid_o <= 1'b0;
                    end
                end
                INJECT: begin
                    if (slot_free) begin
                        valid_o    <= 1'b1;
                        instr_o    <= NOP_INSTR;
                        pc_o       <= marker_pc;
                        fetch_ex_o <= 1'b0;
                        injected_o <= 1'b1;
                        if (inject_cnt_o != '1) begin
                            inject_cnt_o <= inject_cnt_o + CNT_WIDTH'(1);
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ret_marker_nop_injector.sv
// Scoreboard bench for ret_marker_nop_injector: directed return-marker scenarios
// followed by randomized traffic, checked against a queue model of the output stream.
module tb_ret_marker_nop_injector;

    localparam logic [31:0] NOP  = 32'h00100013;
    localparam logic [31:0] RET  = 32'h00008067;
    localparam logic [31:0] CRET = 32'h00008082;
    localparam logic [31:0] ADDI = 32'h00100093;
    localparam logic [31:0] ADD  = 32'h002081b3;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        en_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] instr_i = '0;
    logic [63:0] pc_i = '0;
    logic        fetch_ex_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [31:0] instr_o;
    logic [63:0] pc_o;
    logic        fetch_ex_o;
    logic        injected_o;
    logic [31:0] inject_cnt_o;

    ret_marker_nop_injector dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .en_i         (en_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .instr_i      (instr_i),
        .pc_i         (pc_i),
        .fetch_ex_i   (fetch_ex_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .fetch_ex_o   (fetch_ex_o),
        .injected_o   (injected_o),
        .inject_cnt_o (inject_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic        fex;
        logic        inj;
        bit          counted;
    } item_t;

    item_t       expQ[$];
    int          compared = 0;
    int          mismatched = 0;
    int unsigned modelCnt = 0;
    bit          rstSeen = 1'b0;

    function automatic bit isRet(input logic [31:0] w, input logic fex);
        if (fex) return 1'b0;
        if (w == RET) return 1'b1;
        return (w[1:0] != 2'b11) && (w[15:0] == 16'h8082);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs just after the falling edge.
    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                                 input logic fex, input logic en, input logic rdy,
                                 input logic fl, input logic rs);
        @(negedge clk_i);
        #1;
        valid_i    = v;
        instr_i    = ins;
        pc_i       = pc;
        fetch_ex_i = fex;
        en_i       = en;
        ready_i    = rdy;
        flush_i    = fl;
        rst_i      = rs;
    endtask

    task automatic idleCycles(input int n, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, rdy, 1'b0, 1'b0);
    endtask

    // Holds a word on the input until the block accepts it.
    task automatic sendWord(input logic [31:0] ins, input logic [63:0] pc, input logic fex,
                            input logic en, input logic rdy);
        bit taken = 1'b0;
        for (int i = 0; i < 20 && !taken; i++) begin
            applyStimulus(1'b1, ins, pc, fex, en, rdy, 1'b0, 1'b0);
            #3;
            taken = ready_o;
        end
        if (!taken) checkOutput("sendTimeout", 64'(taken), 64'd1);
    endtask

    // Monitor: samples one time unit before each rising edge.
    always @(negedge clk_i) begin
        #4;
        if (rstSeen) begin
            checkOutput("rstValid", 64'(valid_o), 64'd0);
            checkOutput("rstInstr", 64'(instr_o), 64'd0);
            checkOutput("rstPc", pc_o, 64'd0);
            checkOutput("rstFex", 64'(fetch_ex_o), 64'd0);
            checkOutput("rstInj", 64'(injected_o), 64'd0);
            checkOutput("rstCnt", 64'(inject_cnt_o), 64'd0);
            rstSeen = 1'b0;
        end
        if (rst_i) begin
            expQ.delete();
            modelCnt = 0;
            rstSeen  = 1'b1;
        end else begin
            checkOutput("valid", 64'(valid_o), 64'(expQ.size() != 0));
            if (valid_o && expQ.size() != 0) begin
                checkOutput("instr", 64'(instr_o), 64'(expQ[0].instr));
                checkOutput("pc", pc_o, expQ[0].pc);
                checkOutput("fetchEx", 64'(fetch_ex_o), 64'(expQ[0].fex));
                checkOutput("injected", 64'(injected_o), 64'(expQ[0].inj));
                if (expQ[0].inj && !expQ[0].counted) begin
                    modelCnt++;
                    expQ[0].counted = 1'b1;
                end
            end
            checkOutput("injectCnt", 64'(inject_cnt_o), 64'(modelCnt));
            checkOutput("ready", 64'(ready_o),
                        64'(!flush_i && (expQ.size() == 0 || (expQ.size() == 1 && ready_i))));
            if (expQ.size() != 0 && ready_i) void'(expQ.pop_front());
            if (flush_i) begin
                expQ.delete();
            end else if (valid_i && !flush_i && (expQ.size() == 0 ||
                         (expQ.size() == 0 && ready_i)) && ready_o) begin
                expQ.push_back('{instr_i, pc_i, fetch_ex_i, 1'b0, 1'b0});
                if (isRet(instr_i, fetch_ex_i) && en_i) begin
                    expQ.push_back('{NOP,
                                     pc_i + ((instr_i[1:0] != 2'b11) ? 64'd2 : 64'd4),
                                     1'b0, 1'b1, 1'b0});
                end
            end else if (valid_i && ready_o) begin
                checkOutput("acceptWhileBusy", 64'(ready_o), 64'd0);
            end
        end
    end

    initial begin
        logic [31:0] r;
        logic [63:0] pc;
        logic [31:0] w;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        idleCycles(2, 1'b1);

        sendWord(ADDI, 64'h100, 1'b0, 1'b1, 1'b1);
        sendWord(RET,  64'h104, 1'b0, 1'b1, 1'b1);
        sendWord(ADD,  64'h108, 1'b0, 1'b1, 1'b1);
        idleCycles(3, 1'b1);

        sendWord(CRET, 64'h200, 1'b0, 1'b1, 1'b1);
        idleCycles(3, 1'b1);

        sendWord(RET, 64'h300, 1'b0, 1'b1, 1'b0);
        idleCycles(3, 1'b0);
        idleCycles(3, 1'b1);

        sendWord(RET, 64'h400, 1'b1, 1'b1, 1'b1);
        idleCycles(2, 1'b1);
        sendWord(RET, 64'h404, 1'b0, 1'b0, 1'b1);
        idleCycles(2, 1'b1);

        sendWord(RET, 64'h500, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        sendWord(ADD, 64'h600, 1'b0, 1'b1, 1'b1);
        idleCycles(3, 1'b1);

        sendWord(RET, 64'h700, 1'b0, 1'b1, 1'b1);
        sendWord(RET, 64'h704, 1'b0, 1'b1, 1'b1);
        idleCycles(4, 1'b1);

        sendWord(RET, 64'h800, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idleCycles(3, 1'b1);

        pc = 64'h1000;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom();
            case ($urandom_range(0, 4))
                0: w = RET;
                1: w = CRET;
                2: w = NOP;
                3: begin w = r; w[1:0] = 2'b11; end
                default: begin w = r; w[1:0] = 2'(r[17:16] % 3); end
            endcase
            applyStimulus($urandom_range(0, 3) != 0, w, pc,
                          $urandom_range(0, 9) == 0, $urandom_range(0, 9) != 0,
                          $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                          $urandom_range(0, 199) == 0);
            pc = pc + 64'(2 * $urandom_range(1, 2));
        end

        idleCycles(6, 1'b1);
        #3;
        checkOutput("drainEmpty", 64'(expQ.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
